// File: rtl/multdiv_pkg.sv
// multdiv_pkg
// Shared definitions for the multicycle multiply/divide unit:
//   state_t      - controller states
//   booth_sel_t  - radix-4 Booth partial-product select
//   MUL_ITERS, DIV_ITERS, CNT_W - iteration counts and counter width
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        DIV_FIX,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        PA,
        NA,
        P2A,
        N2A
    } booth_sel_t;

    localparam int MUL_ITERS = 16;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

endpackage

// File: rtl/multdiv_unit_booth_r4_enc.sv
// booth_r4_enc
// Combinational radix-4 Booth recoder.
// Ports:
//   bits - multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   sel  - partial-product select (0, +A, -A, +2A, -2A)
//   neg  - high when the selected multiple is subtracted
module booth_r4_enc
    import multdiv_pkg::*;
(
    input  logic [2:0] bits,
    output booth_sel_t sel,
    output logic       neg
);

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        sel = ZERO;
        unique case (bits)
            3'b001, 3'b010: sel = PA;
            3'b011:         sel = P2A;
            3'b100:         sel = N2A;
            3'b101, 3'b110: sel = NA;
            default:        sel = ZERO;
        endcase
        neg = (sel == NA) || (sel == N2A);
    end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit
// Multicycle signed multiply (radix-4 Booth, 16 iterations) and divide
// (restoring on magnitudes, 32 iterations plus one sign-fix cycle).
// Ports:
//   clock, reset                  - rising-edge clock, synchronous active-high reset
//   data_operandA, data_operandB  - two's complement operands, latched on start
//   ctrl_MULT, ctrl_DIV           - one-cycle start pulses (MULT wins if both)
//   data_result, data_exception   - result and overflow/divide-by-zero flag,
//                                   held until the next completion
//   data_resultRDY                - one-cycle completion pulse
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    input  logic                  ctrl_MULT,
    input  logic                  ctrl_DIV,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY
);

    localparam int W = DATA_WIDTH;

    state_t state, state_nx;

    logic             start_mul, start_div;
    logic [CNT_W-1:0] cnt;
    logic             last_mul, last_div;

    // Multiply datapath: accumulator holds the high part, mq the multiplier
    // (with the appended 0) that fills with low product bits as it shifts.
    logic [W-1:0] mcand;
    logic [W+1:0] acc, acc_nx, mag_term, booth_term, mul_sum;
    logic [W:0]   mq, mq_nx;
    booth_sel_t   sel;
    logic         sel_neg;
    logic         mul_ovf;

    // Divide datapath.
    logic [W-1:0] dsr, quo, quo_nx, quo_fix;
    logic [W:0]   rem, rem_nx;
    logic [W+1:0] div_trial;
    logic         div_ge;
    logic         div_neg, div_ovf, div_zero;
    logic [W-1:0] a_mag, b_mag;

    assign start_mul      = ctrl_MULT;
    assign start_div      = ctrl_DIV & ~ctrl_MULT;
    assign last_mul       = (cnt == CNT_W'(MUL_ITERS - 1));
    assign last_div       = (cnt == CNT_W'(DIV_ITERS - 1));
    assign data_resultRDY = (state == DONE);

    // Magnitudes: 0x80000000 maps to itself, read as unsigned.
    assign a_mag = data_operandA[W-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[W-1] ? -data_operandB : data_operandB;

    booth_r4_enc u_enc (
        .bits (mq[2:0]),
        .sel  (sel),
        .neg  (sel_neg)
    );

    always_comb begin
        unique case (sel)
            PA, NA:   mag_term = {{2{mcand[W-1]}}, mcand};
            P2A, N2A: mag_term = {mcand[W-1], mcand, 1'b0};
            default:  mag_term = '0;
        endcase
        booth_term = sel_neg ? -mag_term : mag_term;
    end

    // Add the Booth term, then shift {acc, mq} right arithmetically by two.
    assign mul_sum = acc + booth_term;
    assign acc_nx  = {{2{mul_sum[W+1]}}, mul_sum[W+1:2]};
    assign mq_nx   = {mul_sum[1:0], mq[W:2]};
    // Low product word sits in mq_nx[W:1]; overflow when the high part is
    // not the sign extension of its top bit.
    assign mul_ovf = (acc_nx != {(W+2){mq_nx[W]}});

    // Restoring step: shift in the next dividend bit and trial-subtract.
    assign div_trial = {rem, quo[W-1]} - {2'b00, dsr};
    assign div_ge    = ~div_trial[W+1];
    assign rem_nx    = div_ge ? div_trial[W:0] : {rem[W-1:0], quo[W-1]};
    assign quo_nx    = {quo[W-2:0], div_ge};
    assign quo_fix   = div_neg ? -quo : quo;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start_mul) begin
            state_nx = MUL_RUN;
        end else if (start_div) begin
            state_nx = DIV_RUN;
        end else begin
            unique case (state)
                IDLE:    state_nx = IDLE;
                MUL_RUN: if (last_mul) state_nx = DONE;
                DIV_RUN: begin
                    if (div_zero)      state_nx = DONE;
                    else if (last_div) state_nx = DIV_FIX;
                end
                DIV_FIX: state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt            <= '0;
            mcand          <= '0;
            acc            <= '0;
            mq             <= '0;
            dsr            <= '0;
            rem            <= '0;
            quo            <= '0;
            div_neg        <= 1'b0;
            div_ovf        <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start_mul) begin
            cnt   <= '0;
            mcand <= data_operandA;
            acc   <= '0;
            mq    <= {data_operandB, 1'b0};
        end else if (start_div) begin
            cnt      <= '0;
            dsr      <= b_mag;
            rem      <= '0;
            quo      <= a_mag;
            div_neg  <= data_operandA[W-1] ^ data_operandB[W-1];
            div_ovf  <= (data_operandA == {1'b1, {(W-1){1'b0}}}) && (&data_operandB);
            div_zero <= (data_operandB == '0);
        end else begin
            unique case (state)
                MUL_RUN: begin
                    acc <= acc_nx;
                    mq  <= mq_nx;
                    cnt <= cnt + 1'b1;
                    if (last_mul) begin
                        data_result    <= mq_nx[W:1];
                        data_exception <= mul_ovf;
                    end
                end
                DIV_RUN: begin
                    if (div_zero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_FIX: begin
                    data_result    <= quo_fix;
                    data_exception <= div_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multicycle signed 32-bit multiply/divide unit in the execute stage, beside the ALU.
- The execute-stage control pulses ctrl_MULT or ctrl_DIV for one cycle. The unit iterates, then pulses data_resultRDY.
- data_result and data_exception feed the writeback mux that also takes the ALU result. The pipeline stalls until data_resultRDY.
- MULT uses radix-4 Booth (16 iterations). DIV uses restoring division on magnitudes (32 iterations) plus one sign-fix cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported and verified.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state at the next rising edge.
- data_operandA  in  32  multiplicand / dividend, two's complement.
- data_operandB  in  32  multiplier / divisor, two's complement.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_result  out  32  low 32 bits of product, or quotient.
- data_exception  out  1  overflow or divide-by-zero, valid with data_result.
- data_resultRDY  out  1  one-cycle completion pulse.

Behaviour:
- Reset state:
  - state IDLE; data_result=0, data_exception=0, data_resultRDY=0.
  - Iteration counter and datapath registers cleared.
  - Reset mid-operation aborts it; no RDY pulse is produced.
- Start:
  - ctrl_MULT or ctrl_DIV is sampled at a rising edge (the start edge, edge 0).
  - Operands are latched at the start edge; later changes to the inputs are ignored.
  - If both are high, MULT wins.
  - A start pulse in any state other than reset aborts the current operation and restarts with the new operands. The aborted operation produces no RDY.
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE.
- MUL_RUN:
  - 34-bit partial-product accumulator plus 33-bit multiplier shift register (B with an appended 0 LSB).
  - Each edge retires 2 multiplier bits: add 0/+A/-A/+2A/-2A, then arithmetic shift right by 2.
  - Edges 1..16 iterate; at edge 16 the state goes to DONE.
  - data_resultRDY is high in the cycle after edge 16 (latency 16).
- MULT overflow: data_exception=1 iff product[63:32] is not the sign extension of product[31]. data_result is still the low 32 bits.
- DIV_RUN:
  - Operates on |A| and |B| using a 33-bit partial remainder. Each edge shifts in one dividend bit, trial-subtracts |B|, and sets the quotient bit if the result is non-negative.
  - Edges 1..32 iterate, then go to DIV_FIX.
  - DIV_FIX negates the quotient if sign(A) xor sign(B), then goes to DONE.
  - RDY is high in the cycle after edge 33 (latency 33).
- DIV rules:
  - Truncation toward zero; the remainder is discarded.
- Divide by zero:
  - Detected at the start edge; goes straight to DONE.
  - data_result=0, data_exception=1, RDY high after edge 1 (latency 1).
- 0x80000000 / -1:
  - Runs the full 33 cycles.
  - data_result=0x80000000, data_exception=1.
- DONE:
  - data_resultRDY=1 for exactly one cycle, then IDLE.
  - A start pulse seen on the DONE edge is accepted (back-to-back operation).
- Result hold:
  - data_result and data_exception update only on the edge entering DONE.
  - They hold through IDLE and the next operation until the next DONE; reset clears them.
- Width rules:
  - The Booth ±2A term is sign-extended to 34 bits.
  - The magnitude of 0x80000000 is 0x80000000, unsigned in 33 bits.

Decomposition:
- Shared package multdiv_pkg:
  - state encoding (IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE);
  - MUL_ITERS=16, DIV_ITERS=32;
  - Booth select encoding (ZERO, PA, NA, P2A, N2A).
- One sub-module, booth_r4_enc: combinational; maps 3 multiplier bits to the select code and a negate flag.

Test Plan:
- MULT 7 x -3 -> data_result=0xFFFFFFEB, exception=0; RDY exactly 16 cycles after the start edge, single-cycle pulse.
- MULT 0x00010000 x 0x00010000 -> result=0x00000000, exception=1. MULT 0x80000000 x 0xFFFFFFFF -> result=0x80000000, exception=1.
- DIV -100 / 7 -> result=0xFFFFFFF2, exception=0, RDY at cycle 33. DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000, exception=1.
- DIV 5 / 0 -> result=0, exception=1, RDY 1 cycle after start. A following MULT 2x3 in the DONE cycle -> result=6, RDY 16 cycles later.
- Start DIV 100/3. Pulse ctrl_MULT with 4x5 at cycle 5 -> no RDY for the DIV; result=20 with RDY 16 cycles after the second pulse. Operand inputs changed mid-op do not alter the result.
- Start MULT, assert reset at cycle 10 -> no RDY ever for that op; outputs 0 after the reset edge. ctrl_MULT and ctrl_DIV both high -> multiply performed.
